// File: rtl/gate_self_tester_if.sv
// Bus between the gate self-tester and its controller/gate block: run control, verdict, stimulus and gate response.
// Optional first-failure capture signals exist only when GATE_SELF_TESTER_FIRST_FAIL_EN is defined.
interface gate_self_tester_if;
    logic       start;
    logic       busy;
    logic       done;
    logic       pass;
    logic [6:0] fail_mask;
    logic       a_drv;
    logic       b_drv;
    logic [6:0] gate_res;
`ifdef GATE_SELF_TESTER_FIRST_FAIL_EN
    logic       first_fail_valid;
    logic [1:0] first_fail_vec;
    logic [6:0] first_fail_res;
`endif

    modport master (
        output start, gate_res,
        input  busy, done, pass, fail_mask, a_drv, b_drv
`ifdef GATE_SELF_TESTER_FIRST_FAIL_EN
        , input first_fail_valid, first_fail_vec, first_fail_res
`endif
    );

    modport slave (
        input  start, gate_res,
        output busy, done, pass, fail_mask, a_drv, b_drv
`ifdef GATE_SELF_TESTER_FIRST_FAIL_EN
        , output first_fail_valid, first_fail_vec, first_fail_res
`endif
    );
endinterface

// File: rtl/gate_self_tester.sv
// Walks a/b through 00,01,10,11, waits SETTLE_CYCLES per vector, checks the seven gate outputs against the truth table.
// Define GATE_SELF_TESTER_FIRST_FAIL_EN to add capture of the first failing vector and its response.
module gate_self_tester #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gate_self_tester_if.slave    bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_CHECK  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       vec_q, vec_d;
    logic [6:0]       fail_mask_q, fail_mask_d;
    logic             pass_q, pass_d;
    logic             done_q, done_d;
    logic             a_drv_q, a_drv_d;
    logic             b_drv_q, b_drv_d;
    logic [6:0]       mismatch;
`ifdef GATE_SELF_TESTER_FIRST_FAIL_EN
    logic             ff_valid_q, ff_valid_d;
    logic [1:0]       ff_vec_q, ff_vec_d;
    logic [6:0]       ff_res_q, ff_res_d;
`endif

    // Bit order: [0] and, [1] or, [2] not(a), [3] nand, [4] nor, [5] xor, [6] xnor.
    function automatic logic [6:0] expected_res(input logic [1:0] v);
        case (v)
            2'd0:    return 7'h5C;
            2'd1:    return 7'h2E;
            2'd2:    return 7'h2A;
            default: return 7'h43;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        vec_d       = vec_q;
        fail_mask_d = fail_mask_q;
        pass_d      = pass_q;
        done_d      = 1'b0;
        a_drv_d     = a_drv_q;
        b_drv_d     = b_drv_q;
        mismatch    = bus.gate_res ^ expected_res(vec_q);
`ifdef GATE_SELF_TESTER_FIRST_FAIL_EN
        ff_valid_d  = ff_valid_q;
        ff_vec_d    = ff_vec_q;
        ff_res_d    = ff_res_q;
`endif
        case (state_q)
            S_IDLE: begin
                a_drv_d = 1'b0;
                b_drv_d = 1'b0;
                if (bus.start) begin
                    state_d     = S_SETTLE;
                    vec_d       = 2'd0;
                    cnt_d       = '0;
                    fail_mask_d = 7'd0;
                    pass_d      = 1'b0;
`ifdef GATE_SELF_TESTER_FIRST_FAIL_EN
                    ff_valid_d  = 1'b0;
                    ff_vec_d    = 2'd0;
                    ff_res_d    = 7'd0;
`endif
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                fail_mask_d = fail_mask_q | mismatch;
`ifdef GATE_SELF_TESTER_FIRST_FAIL_EN
                if (!ff_valid_q && (mismatch != 7'd0)) begin
                    ff_valid_d = 1'b1;
                    ff_vec_d   = vec_q;
                    ff_res_d   = bus.gate_res;
                end
`endif
                if (vec_q == 2'd3) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    // Verdict must include the mismatches found on this final vector.
                    pass_d  = (fail_mask_d == 7'd0);
                end else begin
                    state_d = S_SETTLE;
                    vec_d   = vec_q + 2'd1;
                    cnt_d   = '0;
                    a_drv_d = vec_d[1];
                    b_drv_d = vec_d[0];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                vec_d   = 2'd0;
                a_drv_d = 1'b0;
                b_drv_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            vec_q       <= 2'd0;
            fail_mask_q <= 7'd0;
            pass_q      <= 1'b0;
            done_q      <= 1'b0;
            a_drv_q     <= 1'b0;
            b_drv_q     <= 1'b0;
`ifdef GATE_SELF_TESTER_FIRST_FAIL_EN
            ff_valid_q  <= 1'b0;
            ff_vec_q    <= 2'd0;
            ff_res_q    <= 7'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vec_q       <= vec_d;
            fail_mask_q <= fail_mask_d;
            pass_q      <= pass_d;
            done_q      <= done_d;
            a_drv_q     <= a_drv_d;
            b_drv_q     <= b_drv_d;
`ifdef GATE_SELF_TESTER_FIRST_FAIL_EN
            ff_valid_q  <= ff_valid_d;
            ff_vec_q    <= ff_vec_d;
            ff_res_q    <= ff_res_d;
`endif
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail_mask = fail_mask_q;
    assign bus.a_drv     = a_drv_q;
    assign bus.b_drv     = b_drv_q;
`ifdef GATE_SELF_TESTER_FIRST_FAIL_EN
    assign bus.first_fail_valid = ff_valid_q;
    assign bus.first_fail_vec   = ff_vec_q;
    assign bus.first_fail_res   = ff_res_q;
`endif
endmodule

// File: tb/tb_gate_self_tester.sv
// Bench for gate_self_tester: two instances (SETTLE_CYCLES=2 and =1) driving a behavioural gate model with injectable faults.
// Expected timing, stimulus order and verdicts come from a run-level reference model.
module tb_gate_self_tester;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gate_self_tester_if if0 ();
    gate_self_tester_if if1 ();

    gate_self_tester #(.SETTLE_CYCLES(2), .CNT_W(4)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    gate_self_tester #(.SETTLE_CYCLES(1), .CNT_W(4)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    int errors = 0;
    int checks = 0;

    logic       sel = 1'b0;
    logic       start = 1'b0;
    logic [6:0] sa0 = 7'd0;
    logic [6:0] sa1 = 7'd0;
    logic [6:0] flip_tab [4];

    function automatic logic [6:0] ideal(input logic a, input logic b);
        return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
    endfunction

    function automatic logic [6:0] faulty(input logic a, input logic b);
        return ((ideal(a, b) & ~sa0) | sa1) ^ flip_tab[{a, b}];
    endfunction

    assign if0.start = start & ~sel;
    assign if1.start = start & sel;
    always_comb if0.gate_res = faulty(if0.a_drv, if0.b_drv);
    always_comb if1.gate_res = faulty(if1.a_drv, if1.b_drv);

    logic       o_busy, o_done, o_pass, o_a, o_b;
    logic [6:0] o_mask;
    always_comb begin
        o_busy = sel ? if1.busy      : if0.busy;
        o_done = sel ? if1.done      : if0.done;
        o_pass = sel ? if1.pass      : if0.pass;
        o_a    = sel ? if1.a_drv     : if0.a_drv;
        o_b    = sel ? if1.b_drv     : if0.b_drv;
        o_mask = sel ? if1.fail_mask : if0.fail_mask;
    end
`ifdef GATE_SELF_TESTER_FIRST_FAIL_EN
    logic       o_ffv;
    logic [1:0] o_ffvec;
    logic [6:0] o_ffres;
    always_comb begin
        o_ffv   = sel ? if1.first_fail_valid : if0.first_fail_valid;
        o_ffvec = sel ? if1.first_fail_vec   : if0.first_fail_vec;
        o_ffres = sel ? if1.first_fail_res   : if0.first_fail_res;
    end
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_faults(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] f0,
                              input logic [6:0] f1, input logic [6:0] f2, input logic [6:0] f3);
        sa0 = s0; sa1 = s1;
        flip_tab[0] = f0; flip_tab[1] = f1; flip_tab[2] = f2; flip_tab[3] = f3;
    endtask

    // Called #1 after a rising edge; that cycle is cycle 0 of the run.
    task automatic run_check(input logic sel_i, input bit hold, input bit repulse, input string tag);
        int         s;
        int         d;
        int         v;
        logic [6:0] em;
        logic [6:0] diff;
        logic       ep;
        logic       ffv;
        logic [1:0] ffvec;
        logic [6:0] ffres;
        s = sel_i ? 1 : 2;
        d = 4 * (s + 1) + 1;
        em = 7'd0; ffv = 1'b0; ffvec = 2'd0; ffres = 7'd0;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] kv;
            kv   = 2'(k);
            diff = faulty(kv[1], kv[0]) ^ ideal(kv[1], kv[0]);
            em  |= diff;
            if (!ffv && diff != 7'd0) begin
                ffv = 1'b1; ffvec = kv; ffres = faulty(kv[1], kv[0]);
            end
        end
        ep = (em == 7'd0);
        sel = sel_i;
        start = 1'b1;
        for (int c = 1; c <= d + 1; c++) begin
            @(posedge clk);
            #1;
            start = hold | (repulse && (c == 3 || c == d));
            if (c == 1) begin
                chk({tag, " mask_cleared"}, 32'(o_mask), 32'd0);
                chk({tag, " pass_cleared"}, 32'(o_pass), 32'd0);
`ifdef GATE_SELF_TESTER_FIRST_FAIL_EN
                chk({tag, " ff_cleared"}, 32'(o_ffv), 32'd0);
`endif
            end
            if (c <= d) begin
                chk($sformatf("%s busy@%0d", tag, c), 32'(o_busy), 32'd1);
                chk($sformatf("%s done@%0d", tag, c), 32'(o_done), 32'(c == d));
            end
            if (c < d) begin
                v = (c - 1) / (s + 1);
                chk($sformatf("%s ab@%0d", tag, c), {30'd0, o_a, o_b}, 32'(v));
            end
            if (c == d) begin
                chk({tag, " fail_mask"}, 32'(o_mask), 32'(em));
                chk({tag, " pass"}, 32'(o_pass), 32'(ep));
`ifdef GATE_SELF_TESTER_FIRST_FAIL_EN
                chk({tag, " ff_valid"}, 32'(o_ffv), 32'(ffv));
                chk({tag, " ff_vec"}, 32'(o_ffvec), 32'(ffvec));
                chk({tag, " ff_res"}, 32'(o_ffres), 32'(ffres));
`endif
            end
            if (c == d + 1) begin
                chk({tag, " idle_busy"}, 32'(o_busy), 32'd0);
                chk({tag, " idle_done"}, 32'(o_done), 32'd0);
                chk({tag, " pass_held"}, 32'(o_pass), 32'(ep));
                chk({tag, " mask_held"}, 32'(o_mask), 32'(em));
                chk({tag, " idle_ab"}, {30'd0, o_a, o_b}, 32'd0);
            end
        end
        $display("run %s: settle=%0d fail_mask=0x%02h pass=%0b expected_mask=0x%02h", tag, s, o_mask, o_pass, em);
    endtask

    initial begin
        set_faults(7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0);
        #2;
        chk("rst busy", 32'(if0.busy), 32'd0);
        chk("rst done", 32'(if0.done), 32'd0);
        chk("rst pass", 32'(if0.pass), 32'd0);
        chk("rst mask", 32'(if0.fail_mask), 32'd0);
        chk("rst ab", {30'd0, if0.a_drv, if0.b_drv}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_check(1'b0, 1'b0, 1'b0, "clean");
        set_faults(7'h20, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0);
        run_check(1'b0, 1'b0, 1'b0, "xor_sa0");
        set_faults(7'd0, 7'h01, 7'd0, 7'd0, 7'd0, 7'd0);
        run_check(1'b0, 1'b0, 1'b1, "and_sa1_repulse");
        set_faults(7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0);
        run_check(1'b0, 1'b0, 1'b0, "fresh_after_fail");
        run_check(1'b0, 1'b1, 1'b0, "b2b_1");
        run_check(1'b0, 1'b0, 1'b0, "b2b_2");
        run_check(1'b1, 1'b0, 1'b0, "settle1_clean");
        set_faults(7'd0, 7'd0, 7'd0, 7'd0, 7'h40, 7'h01);
        run_check(1'b1, 1'b0, 1'b0, "settle1_last_vec");

        // Abort a faulty run at cycle 6 and release at cycle 8.
        set_faults(7'd0, 7'h01, 7'd0, 7'd0, 7'd0, 7'd0);
        sel = 1'b0;
        start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1 start = 1'b0;
        end
        chk("pre_reset mask", 32'(o_mask), 32'h01);
        chk("pre_reset busy", 32'(o_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst busy", 32'(o_busy), 32'd0);
        chk("async_rst mask", 32'(o_mask), 32'd0);
        chk("async_rst ab", {30'd0, o_a, o_b}, 32'd0);
        chk("async_rst pass", 32'(o_pass), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst no_done@%0d", c), 32'(o_done), 32'd0);
            chk($sformatf("post_rst idle@%0d", c), 32'(o_busy), 32'd0);
        end
        $display("run reset_abort: no done pulse observed window complete");
        set_faults(7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0);
        run_check(1'b0, 1'b0, 1'b0, "after_reset");

        for (int r = 0; r < 10; r++) begin
            int   mode;
            logic s;
            mode = int'($urandom_range(0, 3));
            s    = 1'($urandom_range(0, 1));
            case (mode)
                0: set_faults(7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0);
                1: set_faults(7'(1 << $urandom_range(0, 6)), 7'd0, 7'd0, 7'd0, 7'd0, 7'd0);
                2: set_faults(7'd0, 7'(1 << $urandom_range(0, 6)), 7'd0, 7'd0, 7'd0, 7'd0);
                default: set_faults(7'd0, 7'd0, 7'($urandom & $urandom), 7'($urandom & $urandom),
                                    7'($urandom & $urandom), 7'($urandom & $urandom));
            endcase
            run_check(s, 1'b0, 1'b0, $sformatf("rand%0d_m%0d", r, mode));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
